// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared load/store opcodes, FSM state type and op-class helpers
package mem_access_ctrl_pkg;

    localparam int ALUOP_W = 8;

    localparam logic [ALUOP_W-1:0] ALU_NOP = 8'h00;
    localparam logic [ALUOP_W-1:0] ALU_LB  = 8'h40;
    localparam logic [ALUOP_W-1:0] ALU_LBU = 8'h41;
    localparam logic [ALUOP_W-1:0] ALU_LH  = 8'h42;
    localparam logic [ALUOP_W-1:0] ALU_LHU = 8'h43;
    localparam logic [ALUOP_W-1:0] ALU_LW  = 8'h44;
    localparam logic [ALUOP_W-1:0] ALU_SB  = 8'h48;
    localparam logic [ALUOP_W-1:0] ALU_SH  = 8'h49;
    localparam logic [ALUOP_W-1:0] ALU_SW  = 8'h4A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_t;

    function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
        return (op == ALU_LB) || (op == ALU_LBU) || (op == ALU_LH) ||
               (op == ALU_LHU) || (op == ALU_LW);
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// rtl/mem_access_ctrl_align.sv - byte-lane steering, load extension and misalignment detection
module mem_access_ctrl_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [1:0]         i_addr_lo,
    input  logic [31:0]        i_st_data,
    input  logic [31:0]        i_rdata,
    output logic               o_is_load,
    output logic               o_is_store,
    output logic               o_misalign,
    output logic [3:0]         o_wen,
    output logic [31:0]        o_wdata,
    output logic [31:0]        o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian: address offset 0 is the least significant lane.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_is_load  = is_load_op(i_aluop);
        o_is_store = is_store_op(i_aluop);
        o_misalign = 1'b0;
        o_wen      = 4'b0000;
        o_wdata    = 32'h0;
        o_ld_data  = 32'h0;
        case (i_aluop)
            ALU_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            ALU_LBU: o_ld_data = {24'h0, w_byte};
            ALU_LH: begin
                o_misalign = i_addr_lo[0];
                o_ld_data  = {{16{w_half[15]}}, w_half};
            end
            ALU_LHU: begin
                o_misalign = i_addr_lo[0];
                o_ld_data  = {16'h0, w_half};
            end
            ALU_LW: begin
                o_misalign = |i_addr_lo;
                o_ld_data  = i_rdata;
            end
            ALU_SB: begin
                o_wen   = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            ALU_SH: begin
                o_misalign = i_addr_lo[0];
                o_wen      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_st_data[15:0]}};
            end
            ALU_SW: begin
                o_misalign = |i_addr_lo;
                o_wen      = 4'b1111;
                o_wdata    = i_st_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-bus controller: request FSM, timeout counter, result hold
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [ALUOP_W-1:0] i_aluop,
    input  logic [ADDR_W-1:0]  i_alures,
    input  logic [DATA_W-1:0]  i_st_data,
    output logic               o_dbus_en,
    output logic [ADDR_W-1:0]  o_dbus_addr,
    output logic [3:0]         o_dbus_wen,
    output logic [DATA_W-1:0]  o_dbus_wdata,
    input  logic [DATA_W-1:0]  i_dbus_rdata,
    input  logic               i_dbus_ack,
    output logic [DATA_W-1:0]  o_mem_rdata,
    output logic               o_exc_adel,
    output logic               o_exc_ades,
    output logic               o_exc_dbe,
    output logic [ADDR_W-1:0]  o_badvaddr,
    output logic [ADDR_W-1:0]  o_exc_pc,
    output logic               o_stallreq
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_hold;
    logic [ALUOP_W-1:0] r_req_op;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [DATA_W-1:0]  r_req_st;
    logic [ADDR_W-1:0]  r_req_pc;

    logic               w_idle;
    logic [ALUOP_W-1:0] w_op;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_st;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_mem_op;
    logic               w_misalign;
    logic [3:0]         w_wen;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_ld_data;
    logic               w_issue;
    logic [CNT_W-1:0]   w_cnt_cur;
    logic               w_timeout;

    // Once a request is in flight the EX/MEM inputs may change (flush), so the
    // bus fields come from the captured request rather than the live inputs.
    assign w_idle = (r_state == S_IDLE);
    assign w_op   = w_idle ? i_aluop   : r_req_op;
    assign w_addr = w_idle ? i_alures  : r_req_addr;
    assign w_st   = w_idle ? i_st_data : r_req_st;
    assign w_pc   = w_idle ? i_pc      : r_req_pc;

    mem_access_ctrl_align u_mem_align_unit (
        .i_aluop    (w_op),
        .i_addr_lo  (w_addr[1:0]),
        .i_st_data  (w_st),
        .i_rdata    (i_dbus_rdata),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_misalign (w_misalign),
        .o_wen      (w_wen),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    assign w_mem_op  = w_is_load | w_is_store;
    assign w_issue   = w_idle && w_mem_op && !w_misalign && !i_flush;
    // The issuing cycle counts as cycle 0 of the wait budget.
    assign w_cnt_cur = (r_state == S_WAIT) ? r_cnt : '0;
    assign w_timeout = (TIMEOUT > 0) && (w_cnt_cur == CNT_LAST) && !i_dbus_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_req_op   <= '0;
            r_req_addr <= '0;
            r_req_st   <= '0;
            r_req_pc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req_op   <= i_aluop;
                        r_req_addr <= i_alures;
                        r_req_st   <= i_st_data;
                        r_req_pc   <= i_pc;
                        if (i_dbus_ack) begin
                            r_hold  <= w_ld_data;
                            r_state <= i_stall ? S_HOLD : S_IDLE;
                        end else if (!w_timeout) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_flush) begin
                        r_state <= i_dbus_ack ? S_IDLE : S_DRAIN;
                    end else if (i_dbus_ack) begin
                        r_hold  <= w_ld_data;
                        r_state <= i_stall ? S_HOLD : S_IDLE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (i_flush || !i_stall) r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (i_dbus_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_dbus_en    = 1'b0;
        o_dbus_addr  = '0;
        o_dbus_wen   = 4'b0000;
        o_dbus_wdata = '0;
        o_mem_rdata  = '0;
        o_exc_adel   = 1'b0;
        o_exc_ades   = 1'b0;
        o_exc_dbe    = 1'b0;
        o_badvaddr   = '0;
        o_exc_pc     = '0;
        o_stallreq   = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        o_dbus_en  = 1'b1;
                        o_stallreq = !i_dbus_ack;
                        if (i_dbus_ack) begin
                            o_mem_rdata = w_ld_data;
                        end else if (w_timeout) begin
                            o_exc_dbe  = 1'b1;
                            o_badvaddr = w_addr;
                            o_exc_pc   = w_pc;
                            o_stallreq = 1'b0;
                        end
                    end else if (w_mem_op && w_misalign && !i_flush) begin
                        o_exc_adel = w_is_load;
                        o_exc_ades = w_is_store;
                        o_badvaddr = w_addr;
                        o_exc_pc   = w_pc;
                    end
                end
                S_WAIT: begin
                    o_dbus_en  = 1'b1;
                    o_stallreq = !i_dbus_ack;
                    if (!i_flush) begin
                        if (i_dbus_ack) begin
                            o_mem_rdata = w_ld_data;
                        end else if (w_timeout) begin
                            o_exc_dbe  = 1'b1;
                            o_badvaddr = w_addr;
                            o_exc_pc   = w_pc;
                            o_stallreq = 1'b0;
                        end
                    end
                end
                S_HOLD: o_mem_rdata = r_hold;
                S_DRAIN: begin
                    o_dbus_en  = 1'b1;
                    o_stallreq = !i_dbus_ack;
                end
                default: ;
            endcase
            if (o_dbus_en) begin
                o_dbus_addr  = {w_addr[ADDR_W-1:2], 2'b00};
                o_dbus_wen   = w_wen;
                o_dbus_wdata = w_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               flush;
    logic [31:0]        pc;
    logic [ALUOP_W-1:0] aluop;
    logic [31:0]        alures;
    logic [31:0]        st_data;
    logic               dbus_en;
    logic [31:0]        dbus_addr;
    logic [3:0]         dbus_wen;
    logic [31:0]        dbus_wdata;
    logic [31:0]        dbus_rdata;
    logic               dbus_ack;
    logic [31:0]        mem_rdata;
    logic               exc_adel;
    logic               exc_ades;
    logic               exc_dbe;
    logic [31:0]        badvaddr;
    logic [31:0]        exc_pc;
    logic               stallreq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_pc         (pc),
        .i_aluop      (aluop),
        .i_alures     (alures),
        .i_st_data    (st_data),
        .o_dbus_en    (dbus_en),
        .o_dbus_addr  (dbus_addr),
        .o_dbus_wen   (dbus_wen),
        .o_dbus_wdata (dbus_wdata),
        .i_dbus_rdata (dbus_rdata),
        .i_dbus_ack   (dbus_ack),
        .o_mem_rdata  (mem_rdata),
        .o_exc_adel   (exc_adel),
        .o_exc_ades   (exc_ades),
        .o_exc_dbe    (exc_dbe),
        .o_badvaddr   (badvaddr),
        .o_exc_pc     (exc_pc),
        .o_stallreq   (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [ALUOP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        aluop   = op;
        alures  = a;
        st_data = d;
        pc      = p;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(ALU_LW, 32'h0000_0100, 32'h0, 32'h0);
        dbus_rdata = 32'h1234_5678; dbus_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dbus_en",  32'(dbus_en), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_wen",      32'(dbus_wen), 32'd0);
        step();
        rst = 1'b0;

        // SB, ack in the issuing cycle
        drive(ALU_SB, 32'h0000_1003, 32'h0000_00AB, 32'h100);
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("sb_en",       32'(dbus_en), 32'd1);
        chk("sb_addr",     dbus_addr, 32'h0000_1000);
        chk("sb_wen",      32'(dbus_wen), 32'h8);
        chk("sb_wdata",    dbus_wdata, 32'hABAB_ABAB);
        chk("sb_stallreq", 32'(stallreq), 32'd0);
        step();

        // LB offset 1 of 0x000080FF, three wait cycles then ack
        drive(ALU_LB, 32'h0000_2001, 32'h0, 32'h104);
        dbus_rdata = 32'h0000_80FF; dbus_ack = 1'b0;
        exp_q.push_back(32'hFFFF_FF80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_wait_stallreq", 32'(stallreq), 32'd1);
            chk("lb_wait_addr", dbus_addr, 32'h0000_2000);
            chk("lb_wait_dbe", 32'(exc_dbe), 32'd0);
            step();
        end
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("lb_ack_stallreq", 32'(stallreq), 32'd0);
        chk("lb_ack_wen", 32'(dbus_wen), 32'd0);
        chk_pop("lb_rdata", mem_rdata);
        step();

        // LBU same address, one wait cycle
        drive(ALU_LBU, 32'h0000_2001, 32'h0, 32'h108);
        dbus_ack = 1'b0;
        exp_q.push_back(32'h0000_0080);
        @(negedge clk);
        chk("lbu_wait_stallreq", 32'(stallreq), 32'd1);
        step();
        dbus_ack = 1'b1;
        @(negedge clk);
        chk_pop("lbu_rdata", mem_rdata);
        step();

        // LB offset 0, LH offset 2, both acked at once
        drive(ALU_LB, 32'h0000_2000, 32'h0, 32'h10C);
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clk);
        chk_pop("lb0_rdata", mem_rdata);
        step();
        drive(ALU_LH, 32'h0000_2002, 32'h0, 32'h110);
        dbus_rdata = 32'h8001_1234;
        exp_q.push_back(32'hFFFF_8001);
        @(negedge clk);
        chk_pop("lh_rdata", mem_rdata);
        step();

        // SH upper half
        drive(ALU_SH, 32'h0000_0002, 32'h1234_CAFE, 32'h114);
        @(negedge clk);
        chk("sh_wen",   32'(dbus_wen), 32'hC);
        chk("sh_wdata", dbus_wdata, 32'hCAFE_CAFE);
        step();

        // Misaligned LW / SH: no bus access
        drive(ALU_LW, 32'h0000_3002, 32'h0, 32'h118);
        @(negedge clk);
        chk("lw_mis_adel",  32'(exc_adel), 32'd1);
        chk("lw_mis_badva", badvaddr, 32'h0000_3002);
        chk("lw_mis_pc",    exc_pc, 32'h118);
        chk("lw_mis_en",    32'(dbus_en), 32'd0);
        chk("lw_mis_stall", 32'(stallreq), 32'd0);
        step();
        drive(ALU_SH, 32'h0000_3001, 32'h0, 32'h11C);
        @(negedge clk);
        chk("sh_mis_ades", 32'(exc_ades), 32'd1);
        chk("sh_mis_adel", 32'(exc_adel), 32'd0);
        chk("sh_mis_en",   32'(dbus_en), 32'd0);
        step();

        // flush beats a new request in IDLE
        drive(ALU_LW, 32'h0000_3000, 32'h0, 32'h120);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_en", 32'(dbus_en), 32'd0);
        step();
        flush = 1'b0;

        // Timeout: TIMEOUT=4 -> exc_dbe in the 4th cycle of the request
        drive(ALU_LW, 32'h0000_5000, 32'h0, 32'h124);
        dbus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_wait_en", 32'(dbus_en), 32'd1);
            chk("to_wait_dbe", 32'(exc_dbe), 32'd0);
            chk("to_wait_stallreq", 32'(stallreq), 32'd1);
            step();
        end
        @(negedge clk);
        chk("to_dbe",      32'(exc_dbe), 32'd1);
        chk("to_en",       32'(dbus_en), 32'd1);
        chk("to_badva",    badvaddr, 32'h0000_5000);
        chk("to_stallreq", 32'(stallreq), 32'd0);
        step();
        drive(ALU_NOP, 32'h0, 32'h0, 32'h128);
        @(negedge clk);
        chk("to_after_dbe", 32'(exc_dbe), 32'd0);
        chk("to_after_en",  32'(dbus_en), 32'd0);
        step();

        // LHU acked under stall -> HOLD keeps result
        drive(ALU_LHU, 32'h0000_4002, 32'h0, 32'h12C);
        dbus_rdata = 32'hBEEF_0000; dbus_ack = 1'b1; stall = 1'b1;
        exp_q.push_back(32'h0000_BEEF);
        @(negedge clk);
        chk_pop("lhu_rdata", mem_rdata);
        chk("lhu_stallreq", 32'(stallreq), 32'd0);
        step();
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        @(negedge clk);
        chk("hold_en",    32'(dbus_en), 32'd0);
        chk("hold_rdata", mem_rdata, 32'h0000_BEEF);
        step();
        stall = 1'b0;
        @(negedge clk);
        chk("hold_release_rdata", mem_rdata, 32'h0000_BEEF);
        step();
        drive(ALU_NOP, 32'h0, 32'h0, 32'h130);
        @(negedge clk);
        chk("hold_exit_rdata", mem_rdata, 32'h0);
        step();

        // flush during WAIT -> DRAIN until ack, new op only afterwards
        drive(ALU_LW, 32'h0000_6000, 32'h0, 32'h134);
        @(negedge clk);
        chk("drain_issue_en", 32'(dbus_en), 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("drain_flush_en",  32'(dbus_en), 32'd1);
        chk("drain_flush_stl", 32'(stallreq), 32'd1);
        chk("drain_flush_adel", 32'(exc_adel), 32'd0);
        step();
        flush = 1'b0;
        drive(ALU_SW, 32'h0000_7000, 32'h55AA_55AA, 32'h138);
        @(negedge clk);
        chk("drain_en",   32'(dbus_en), 32'd1);
        chk("drain_addr", dbus_addr, 32'h0000_6000);
        chk("drain_wen",  32'(dbus_wen), 32'd0);
        chk("drain_stl",  32'(stallreq), 32'd1);
        step();
        dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("drain_ack_addr",  dbus_addr, 32'h0000_6000);
        chk("drain_ack_stl",   32'(stallreq), 32'd0);
        chk("drain_ack_rdata", mem_rdata, 32'h0);
        chk("drain_ack_dbe",   32'(exc_dbe), 32'd0);
        step();
        @(negedge clk);
        chk("post_drain_addr",  dbus_addr, 32'h0000_7000);
        chk("post_drain_wen",   32'(dbus_wen), 32'hF);
        chk("post_drain_wdata", dbus_wdata, 32'h55AA_55AA);
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
